// File: rtl/updown_sequencer.sv
// Up/down sweep sequencer driving an external 5-bit counter: clear, count up to target, count down to zero.
// Optional tracking-error monitor enabled by defining SEQ_CHECK_EN; otherwise err is tied low.
module updown_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] target,
  input  logic [4:0] cnt_val,
  input  logic       down_done,
  output logic       cntU,
  output logic       cntD,
  output logic       rst5,
  output logic       busy,
  output logic       done,
  output logic [4:0] peak,
  output logic       err
);

  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {IDLE, CLR, UP, DOWN, FIN} state_t;

  state_t        state_q, state_nx;
  logic [CW-1:0] tgt_q;
  logic          accept_c;
  logic          rst5_nx, busy_nx, done_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  // Next state; cntU/cntD follow the counter combinationally, the rest are decoded from next state
  always_comb begin
    state_nx = state_q;
    cntU     = 1'b0;
    cntD     = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = CLR;
        end
      end
      CLR:  state_nx = UP;
      UP: begin
        cntU = (cnt_val != tgt_q);
        if (cnt_val == tgt_q) state_nx = DOWN;
      end
      DOWN: begin
        cntD = !down_done;
        if (down_done) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    rst5_nx = (state_nx == CLR);
    done_nx = (state_nx == FIN);
    busy_nx = (state_nx != IDLE);
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      rst5 <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      rst5 <= rst5_nx;
      done <= done_nx;
      busy <= busy_nx;
    end
  end

  // Target latch and peak tracker; peak survives the return to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= CW'(0);
      peak  <= CW'(0);
    end else if (accept_c) begin
      tgt_q <= target;
      peak  <= CW'(0);
    end else if (state_q == UP && cnt_val > peak) begin
      peak  <= cnt_val;
    end
  end

`ifdef SEQ_CHECK_EN
  logic track_bad_c;

  // Counter overshoot, or zero flag disagreeing with the counter value while counting down
  always_comb begin
    track_bad_c = 1'b0;
    if ((state_q == UP || state_q == DOWN) && cnt_val > tgt_q) track_bad_c = 1'b1;
    if (state_q == DOWN && (down_done != (cnt_val == CW'(0))))   track_bad_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)              err <= 1'b0;
    else if (accept_c)    err <= 1'b0;
    else if (track_bad_c) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_updown_sequencer.sv
// Self-checking bench for updown_sequencer with a behavioural 5-bit counter and a per-sweep scoreboard.
// Define SEQ_CHECK_EN for both RTL and bench to exercise the tracking-error monitor.
module tb_updown_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] target;
  logic [4:0] cnt_val;
  logic       down_done;
  logic       cntU, cntD, rst5, busy, done;
  logic [4:0] peak;
  logic       err;

  logic [4:0] cnt;
  logic       force_en;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int done_cyc;
    int n_up;
    int n_dn;
    int peak;
    int err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  updown_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .target    (target),
    .cnt_val   (cnt_val),
    .down_done (down_done),
    .cntU      (cntU),
    .cntD      (cntD),
    .rst5      (rst5),
    .busy      (busy),
    .done      (done),
    .peak      (peak),
    .err       (err)
  );

  // Compliant counter: one-cycle update, cleared by its own reset or rst5
  always @(posedge clk) begin
    if (rst || rst5) cnt <= 5'd0;
    else if (cntU)   cnt <= cnt + 5'd1;
    else if (cntD)   cnt <= cnt - 5'd1;
  end

  assign cnt_val   = force_en ? 5'd7 : cnt;
  assign down_done = (cnt == 5'd0);

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: plain sweep; 1: restart/target change during UP; 2: rst during DOWN; 3: corrupt cnt_val in DOWN
  task automatic sweep(input logic [4:0] tgt, input int mode);
    exp_t e;
    int   n_up = 0, n_dn = 0, n_rst5 = 0, rst5_cyc = -1, done_cyc = -1, bad = 0;
    int   limit;
    int   n = int'(tgt);
    limit = (mode == 2) ? 25 : 80;
    e.done_cyc = (mode == 2) ? -1 : 2 * n + 4;
    e.n_up     = (mode == 2) ? -1 : n;
    e.n_dn     = (mode == 2) ? -1 : n;
    e.peak     = (mode == 2) ? 0 : n;
    e.err      = (mode == 3) ? 1 : 0;
    sb.push_back(e);

    @(negedge clk);
    start  = 1'b1;
    target = tgt;
    for (int c = 1; c <= limit && done_cyc < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cntU) n_up++;
      if (cntD) n_dn++;
      if (rst5) begin
        n_rst5++;
        if (rst5_cyc < 0) rst5_cyc = c;
      end
      if (done) done_cyc = c;
      if (int'(cntU) + int'(cntD) + int'(rst5) > 1) bad++;
      if (cntU && cnt == 5'd31) bad++;
      if (!busy && (mode != 2 || c <= 11)) bad++;
      if (mode == 1 && c == 3) begin
        start  = 1'b1;
        target = 5'd9;
      end
      if (mode == 2 && c == 11) rst = 1'b1;
      if (mode == 2 && c == 12) begin
        chk("abort_busy", int'(busy), 0);
        chk("abort_cntD", int'(cntD), 0);
        chk("abort_rst5", int'(rst5), 0);
        rst = 1'b0;
      end
      if (mode == 3) force_en = (c == 8);
    end
    force_en = 1'b0;

    e = sb.pop_front();
    chk("rst5_cycle", rst5_cyc, 1);
    chk("rst5_count", n_rst5, 1);
    chk("done_cycle", done_cyc, e.done_cyc);
    if (e.n_up >= 0) chk("cntU_count", n_up, e.n_up);
    if (e.n_dn >= 0) chk("cntD_count", n_dn, e.n_dn);
    chk("peak", int'(peak), e.peak);
    chk("err", int'(err), e.err);
    chk("protocol", bad, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    target   = 5'd0;
    force_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cmds", int'(cntU) + int'(cntD) + int'(rst5), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_err",  int'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    sweep(5'd5, 0);
    sweep(5'd0, 0);
    sweep(5'd31, 0);
    sweep(5'd3, 1);
    sweep(5'd9, 0);
    sweep(5'd6, 2);
    sweep(5'd1, 0);
`ifdef SEQ_CHECK_EN
    sweep(5'd4, 3);
    repeat (3) @(negedge clk);
    chk("err_hold", int'(err), 1);
    sweep(5'd2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/updown_sequencer.md
UPDOWN_SEQUENCER -- requirements
Module: updown_sequencer

Interface
REQ-001 The block SHALL have no parameters; all count widths are fixed at 5 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 start  input  1  request to run one up/down sweep; sampled only in IDLE.
REQ-005 target  input  5  sweep peak value, unsigned 0..31; latched on start acceptance.
REQ-006 cnt_val  input  5  current value of the controlled 5-bit up/down counter.
REQ-007 down_done  input  1  counter-at-zero flag from the controlled counter.
REQ-008 cntU  output  1  count-up command to the counter.
REQ-009 cntD  output  1  count-down command to the counter.
REQ-010 rst5  output  1  counter clear command.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 peak  output  5  largest cnt_val sampled in UP during the current or last sweep.
REQ-014 err  output  1  sticky tracking error (REQ-030/031).

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, CLR, UP, DOWN, FIN.
REQ-016 IDLE: start=1 SHALL latch target into tgt_q, clear peak and err, and go to CLR; start=0 stays in IDLE.
REQ-017 CLR: rst5 SHALL be 1 for exactly this one cycle; next state UP unconditionally.
REQ-018 UP: cntU SHALL equal (cnt_val != tgt_q), combinationally; when cnt_val == tgt_q the next state SHALL be DOWN.
REQ-019 DOWN: cntD SHALL equal (down_done == 0), combinationally; when down_done == 1 the next state SHALL be FIN.
REQ-020 FIN: done SHALL be 1 for this single cycle; next state IDLE.
REQ-021 cntU, cntD, rst5 SHALL never be asserted together; all three SHALL be 0 in IDLE and FIN.
REQ-022 peak SHALL load cnt_val on every UP cycle where cnt_val > peak; it holds otherwise, including after return to IDLE.
REQ-023 With start high in cycle k and a compliant counter (1-cycle update), CLR is in k+1, UP in k+2..k+N+2, DOWN in k+N+3..k+2N+3, FIN in k+2N+4, where N = tgt_q.
REQ-024 A sweep SHALL issue exactly N cntU cycles and exactly N cntD cycles.
REQ-025 tgt_q = 0: UP and DOWN SHALL each last one cycle with no cntU/cntD; done arrives at k+4.
REQ-026 tgt_q = 31: the counter SHALL reach 31 without wrap; cntU SHALL deassert in the cycle cnt_val == 31.
REQ-027 start asserted while busy SHALL be ignored; target changes while busy SHALL not affect tgt_q.

Reset
REQ-028 rst=1 SHALL force IDLE, tgt_q=0, peak=0, err=0; cntU=cntD=rst5=busy=done=0 in the following cycle.
REQ-029 rst mid-sweep SHALL abort without issuing rst5; the counter's own reset is responsible for clearing it.

Configuration
REQ-030 With SEQ_CHECK_EN defined, err SHALL set (sticky) when, in UP or DOWN, cnt_val > tgt_q; or, in DOWN, down_done != (cnt_val == 0).
REQ-031 With SEQ_CHECK_EN defined, err SHALL clear only on rst or on start acceptance; it does not affect FSM flow.
REQ-032 Without SEQ_CHECK_EN, err SHALL be tied to 0 and no check logic SHALL be synthesised; the port remains.

Verification
REQ-033 Drive target=5 with start in cycle 0, using a model 5-bit counter -> exactly 5 cntU and 5 cntD pulses; done in cycle 14; peak=5; err=0.
REQ-034 Drive target=0 -> no cntU/cntD; rst5 in cycle 1; done in cycle 4; peak=0.
REQ-035 Drive target=31 -> counter reaches 31 with no wrap; 31 cntU and 31 cntD pulses; done in cycle 66; peak=31.
REQ-036 Pulse start again and change target to 9 in the UP phase of a target=3 sweep -> ignored; sweep completes with peak=3; the next start with target=9 works.
REQ-037 Assert rst in DOWN -> next cycle state IDLE; busy=cntD=0; no done pulse.
REQ-038 With SEQ_CHECK_EN, force cnt_val=7 during the DOWN phase of a target=4 sweep -> err=1 and held until the next start.
